// File: rtl/apb2axi_axi_master_if.sv
// Bundle of the request-pop, AXI4-Lite style master and completion channels
// for apb2axi_axi_master. The master modport is the block's view; slave is
// the view of whatever sits on the other side (FIFO, AXI slave, APB side).
interface apb2axi_axi_master_if #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ENTRY_WIDTH = 1 + ADDR_W + DATA_W + DATA_W/8
);
    // request FIFO pop side
    logic                   req_valid;
    logic                   req_ready;
    logic [ENTRY_WIDTH-1:0] req_data;
    // AXI write address / data / response
    logic [ADDR_W-1:0]      awaddr;
    logic                   awvalid;
    logic                   awready;
    logic [DATA_W-1:0]      wdata;
    logic [DATA_W/8-1:0]    wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    // AXI read address / data
    logic [ADDR_W-1:0]      araddr;
    logic                   arvalid;
    logic                   arready;
    logic [DATA_W-1:0]      rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;
    // completion toward the APB side
    logic                   cpl_valid;
    logic                   cpl_ready;
    logic                   cpl_is_write;
    logic [1:0]             cpl_resp;
    logic [DATA_W-1:0]      cpl_rdata;

    modport master (
        input  req_valid, req_data,
        output req_ready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid,
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid,
        output cpl_valid, cpl_is_write, cpl_resp, cpl_rdata,
        input  cpl_ready
    );

    modport slave (
        output req_valid, req_data,
        input  req_ready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid,
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid,
        input  cpl_valid, cpl_is_write, cpl_resp, cpl_rdata,
        output cpl_ready
    );
endinterface

// File: rtl/apb2axi_axi_master.sv
// APB2AXI AXI master: pops one request entry from the request FIFO, runs it as
// a single-beat AXI write (AW/W/B) or read (AR/R), and hands the response back
// on the completion channel. Strictly one transaction in flight.
module apb2axi_axi_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ENTRY_WIDTH = 1 + ADDR_W + DATA_W + DATA_W/8
) (
    input  logic                clk,
    input  logic                reset,
    apb2axi_axi_master_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        CPL
    } state_t;

    state_t state;
    logic   aw_done;   // AW handshake already taken in this write
    logic   w_done;    // W handshake already taken in this write
    logic   aw_fin;
    logic   w_fin;

    // Either a handshake earlier in this write or one happening this cycle.
    assign aw_fin = aw_done || (bus.awvalid && bus.awready);
    assign w_fin  = w_done  || (bus.wvalid  && bus.wready);

    // Only pop while idle; gated by reset so nothing is lost on the reset edge.
    assign bus.req_ready = (state == IDLE) && !reset;

    // Transaction FSM; all bus outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            bus.awaddr       <= '0;
            bus.awvalid      <= 1'b0;
            bus.wdata        <= '0;
            bus.wstrb        <= '0;
            bus.wvalid       <= 1'b0;
            bus.bready       <= 1'b0;
            bus.araddr       <= '0;
            bus.arvalid      <= 1'b0;
            bus.rready       <= 1'b0;
            bus.cpl_valid    <= 1'b0;
            bus.cpl_is_write <= 1'b0;
            bus.cpl_resp     <= 2'b00;
            bus.cpl_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        // entry layout, MSB first: {is_write, addr, wdata, wstrb}
                        if (bus.req_data[ENTRY_WIDTH-1]) begin
                            bus.awaddr  <= bus.req_data[ENTRY_WIDTH-2 -: ADDR_W];
                            bus.wdata   <= bus.req_data[STRB_W +: DATA_W];
                            bus.wstrb   <= bus.req_data[STRB_W-1:0];
                            bus.awvalid <= 1'b1;
                            bus.wvalid  <= 1'b1;
                            state       <= WR_REQ;
                        end else begin
                            bus.araddr  <= bus.req_data[ENTRY_WIDTH-2 -: ADDR_W];
                            bus.arvalid <= 1'b1;
                            state       <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    // AW and W retire independently, in any order
                    if (bus.awvalid && bus.awready) bus.awvalid <= 1'b0;
                    if (bus.wvalid && bus.wready)   bus.wvalid  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        bus.bready <= 1'b1;
                        state      <= WR_RESP;
                    end else begin
                        aw_done <= aw_fin;
                        w_done  <= w_fin;
                    end
                end
                WR_RESP: begin
                    if (bus.bvalid) begin
                        bus.bready       <= 1'b0;
                        bus.cpl_valid    <= 1'b1;
                        bus.cpl_is_write <= 1'b1;
                        bus.cpl_resp     <= bus.bresp;
                        bus.cpl_rdata    <= '0;
                        state            <= CPL;
                    end
                end
                RD_REQ: begin
                    if (bus.arready) begin
                        bus.arvalid <= 1'b0;
                        bus.rready  <= 1'b1;
                        state       <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    // data is kept even on SLVERR/DECERR
                    if (bus.rvalid) begin
                        bus.rready       <= 1'b0;
                        bus.cpl_valid    <= 1'b1;
                        bus.cpl_is_write <= 1'b0;
                        bus.cpl_resp     <= bus.rresp;
                        bus.cpl_rdata    <= bus.rdata;
                        state            <= CPL;
                    end
                end
                CPL: begin
                    if (bus.cpl_ready) begin
                        bus.cpl_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb2axi_axi_master.sv
// Bench for apb2axi_axi_master: request source, randomized AXI slave with a
// sparse memory, and a scoreboard fed by a transaction-level reference model.
module tb_apb2axi_axi_master;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  resp;     // response the slave will return
    } txn_t;

    typedef struct packed {
        logic        is_write;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } cpl_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    apb2axi_axi_master_if #(.ADDR_W(AW), .DATA_W(DW)) b ();

    apb2axi_axi_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b.master)
    );

    int total = 0;
    int bad   = 0;

    txn_t req_q[$];   // waiting to be offered to the DUT
    txn_t slv_q[$];   // accepted by DUT, slave response pending
    cpl_t exp_q[$];   // scoreboard

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    // knobs
    int aw_pct = 100, w_pct = 100, ar_pct = 100, cpl_pct = 100;
    logic cpl_hold = 1'b0, r_hold = 1'b0;

    // monitor -> driver
    logic hs_req = 0, hs_aw = 0, hs_w = 0, hs_b = 0, hs_ar = 0, hs_r = 0, hs_cpl = 0, rst_seen = 0;
    logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
    logic [3:0]  cap_wstrb = 0;
    txn_t drv_txn, cur;
    cpl_t mon_e;
    int   outstanding = 0, ncpl = 0;
    logic pop_chk = 0, post_cpl = 0;

    // previous-sample snapshot for hold/stability checks
    logic p_ok = 0, p_awv = 0, p_wv = 0, p_arv = 0, p_cv = 0;
    logic p_awh = 0, p_wh = 0, p_arh = 0, p_ch = 0, p_cwr = 0;
    logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0, p_crd = 0;
    logic [3:0]  p_wstrb = 0;
    logic [1:0]  p_cresp = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Reference model: what the completion of a transaction must be.
    function automatic cpl_t model(input txn_t t);
        cpl_t c;
        logic [31:0] old;
        old = ref_mem.exists(t.addr) ? ref_mem[t.addr] : dflt(t.addr);
        c.is_write = t.is_write;
        c.resp     = t.resp;
        if (t.is_write) begin
            ref_mem[t.addr] = merge(old, t.wdata, t.wstrb);
            c.rdata = '0;
        end else begin
            c.rdata = old;
        end
        return c;
    endfunction

    // Monitor: samples mid-cycle, checks protocol and scoreboard.
    always @(negedge clk) begin
        hs_req   = b.req_valid && b.req_ready;
        hs_aw    = b.awvalid && b.awready;
        hs_w     = b.wvalid && b.wready;
        hs_b     = b.bvalid && b.bready;
        hs_ar    = b.arvalid && b.arready;
        hs_r     = b.rvalid && b.rready;
        hs_cpl   = b.cpl_valid && b.cpl_ready;
        rst_seen = reset;
        if (reset) begin
            exp_q.delete();
            outstanding = 0;
            pop_chk = 0; post_cpl = 0; p_ok = 0;
            hs_req = 0; hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0; hs_cpl = 0;
        end else begin
            if (p_ok) begin
                if (p_awv && !p_awh) chk("aw_hold", {b.awvalid, b.awaddr}, {1'b1, p_awaddr});
                if (p_wv && !p_wh)   chk("w_hold", {b.wvalid, b.wdata, b.wstrb}, {1'b1, p_wdata, p_wstrb});
                if (p_arv && !p_arh) chk("ar_hold", {b.arvalid, b.araddr}, {1'b1, p_araddr});
                if (p_cv && !p_ch)
                    chk("cpl_hold", {b.cpl_valid, b.cpl_is_write, b.cpl_resp, b.cpl_rdata},
                        {1'b1, p_cwr, p_cresp, p_crd});
            end
            if (pop_chk) begin
                chk("pop_latency", {b.awvalid, b.wvalid, b.arvalid}, cur.is_write ? 3'b110 : 3'b001);
                pop_chk = 0;
            end
            if (post_cpl) begin
                chk("ready_after_cpl", b.req_ready, 1);
                post_cpl = 0;
            end
            if (b.awvalid || b.wvalid || b.arvalid || b.cpl_valid || b.bready || b.rready)
                chk("ready_while_busy", b.req_ready, 0);
            if (b.bready || b.rready)
                chk("resp_ready_excl", {b.bready && b.rready,
                    b.awvalid || b.wvalid || b.arvalid || b.cpl_valid}, 0);
            if (hs_aw) begin
                chk("aw_payload", {cur.is_write, b.awaddr}, {1'b1, cur.addr});
                cap_awaddr = b.awaddr;
            end
            if (hs_w) begin
                chk("w_payload", {cur.is_write, b.wdata, b.wstrb}, {1'b1, cur.wdata, cur.wstrb});
                cap_wdata = b.wdata; cap_wstrb = b.wstrb;
            end
            if (hs_ar) begin
                chk("ar_payload", {cur.is_write, b.araddr}, {1'b0, cur.addr});
                cap_araddr = b.araddr;
            end
            if (hs_cpl) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cpl_unexpected actual=completion expected=none t=%0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("cpl_fields", {b.cpl_is_write, b.cpl_resp, b.cpl_rdata},
                        {mon_e.is_write, mon_e.resp, mon_e.rdata});
                end
                ncpl++;
                outstanding = 0;
                post_cpl = 1;
            end
            if (hs_req) begin
                chk("one_outstanding", outstanding, 0);
                cur = drv_txn;
                exp_q.push_back(model(drv_txn));
                slv_q.push_back(drv_txn);
                outstanding = 1;
                pop_chk = 1;
            end
            p_awv = b.awvalid; p_wv = b.wvalid; p_arv = b.arvalid; p_cv = b.cpl_valid;
            p_awh = hs_aw; p_wh = hs_w; p_arh = hs_ar; p_ch = hs_cpl;
            p_awaddr = b.awaddr; p_wdata = b.wdata; p_wstrb = b.wstrb; p_araddr = b.araddr;
            p_cwr = b.cpl_is_write; p_cresp = b.cpl_resp; p_crd = b.cpl_rdata;
            p_ok = 1;
        end
    end

    // Driver: request source, AXI slave, completion sink; updates after each edge.
    initial begin : driver
        logic aw_got, w_got, ar_got, b_arm, r_arm;
        int   b_cnt, r_cnt;
        logic [31:0] old;
        aw_got = 0; w_got = 0; ar_got = 0; b_arm = 0; r_arm = 0; b_cnt = 0; r_cnt = 0;
        b.req_valid = 0; b.req_data = '0;
        b.awready = 0; b.wready = 0; b.arready = 0;
        b.bvalid = 0; b.bresp = 0; b.rvalid = 0; b.rresp = 0; b.rdata = 0;
        b.cpl_ready = 0;
        forever begin
            @(posedge clk); #1;
            if (rst_seen) begin
                b.awready = 0; b.wready = 0; b.arready = 0; b.bvalid = 0; b.rvalid = 0;
                b.req_valid = 0; b.cpl_ready = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_arm = 0; r_arm = 0;
                slv_q.delete();
            end else begin
                if (hs_req) b.req_valid = 0;
                if (!b.req_valid && req_q.size() != 0) begin
                    drv_txn = req_q.pop_front();
                    b.req_valid = 1;
                    b.req_data = {drv_txn.is_write, drv_txn.addr, drv_txn.wdata, drv_txn.wstrb};
                end
                if (hs_aw) aw_got = 1;
                if (hs_w)  w_got = 1;
                if (hs_b) begin
                    b.bvalid = 0; aw_got = 0; w_got = 0; b_arm = 0;
                    if (slv_q.size() != 0) slv_q.delete(0);
                end else if (aw_got && w_got && !b.bvalid && slv_q.size() != 0) begin
                    if (!b_arm) begin b_arm = 1; b_cnt = $urandom_range(3, 0); end
                    if (b_cnt == 0) begin
                        old = slv_mem.exists(cap_awaddr) ? slv_mem[cap_awaddr] : dflt(cap_awaddr);
                        slv_mem[cap_awaddr] = merge(old, cap_wdata, cap_wstrb);
                        b.bresp = slv_q[0].resp;
                        b.bvalid = 1;
                    end else b_cnt--;
                end
                if (hs_ar) ar_got = 1;
                if (hs_r) begin
                    b.rvalid = 0; ar_got = 0; r_arm = 0;
                    if (slv_q.size() != 0) slv_q.delete(0);
                end else if (ar_got && !b.rvalid && !r_hold && slv_q.size() != 0) begin
                    if (!r_arm) begin r_arm = 1; r_cnt = $urandom_range(3, 0); end
                    if (r_cnt == 0) begin
                        b.rdata = slv_mem.exists(cap_araddr) ? slv_mem[cap_araddr] : dflt(cap_araddr);
                        b.rresp = slv_q[0].resp;
                        b.rvalid = 1;
                    end else r_cnt--;
                end
                b.awready   = ($urandom_range(99, 0) < aw_pct);
                b.wready    = ($urandom_range(99, 0) < w_pct);
                b.arready   = ($urandom_range(99, 0) < ar_pct);
                b.cpl_ready = !cpl_hold && ($urandom_range(99, 0) < cpl_pct);
            end
        end
    end

    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] r);
        txn_t t;
        t.is_write = w; t.addr = a; t.wdata = d; t.wstrb = s; t.resp = r;
        req_q.push_back(t);
    endtask

    task automatic wait_cpl(input int target, input int budget);
        int n = 0;
        while (ncpl < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("cpl_count", ncpl, target);
    endtask

    task automatic wait_sig(input string nm, input int which, input int budget);
        int n = 0;
        logic s = 0;
        while (!s && n < budget) begin
            @(negedge clk); #1;
            s = (which == 0) ? b.cpl_valid : b.rready;
            n++;
        end
        chk(nm, s, 1);
    endtask

    initial begin : main
        int base;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {b.req_ready, b.awvalid, b.wvalid, b.bready, b.arvalid, b.rready, b.cpl_valid}, 0);
        chk("reset_addr", {b.awaddr, b.araddr}, 0);
        chk("reset_wdata", {b.wdata, b.wstrb}, 0);
        chk("reset_cpl", {b.cpl_is_write, b.cpl_resp, b.cpl_rdata}, 0);
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("idle_ready", b.req_ready, 1);

        // write, AW and W ready together
        push(1, 32'h1000, 32'hDEADBEEF, 4'hF, 2'b00);
        wait_cpl(1, 200);

        // write with W before AW, then AW before W
        aw_pct = 0;
        push(1, 32'h1004, 32'hCAFEF00D, 4'h5, 2'b00);
        repeat (5) @(negedge clk);
        aw_pct = 100;
        wait_cpl(2, 200);
        w_pct = 0;
        push(1, 32'h1008, 32'h01020304, 4'hA, 2'b11);
        repeat (5) @(negedge clk);
        w_pct = 100;
        wait_cpl(3, 200);

        // read with SLVERR and delayed arready
        ref_mem[32'h2004] = 32'h12345678;
        slv_mem[32'h2004] = 32'h12345678;
        ar_pct = 25;
        push(0, 32'h2004, 32'h0, 4'h0, 2'b10);
        wait_cpl(4, 400);
        ar_pct = 100;

        // completion backpressure with a second request waiting
        cpl_hold = 1;
        push(0, 32'h1004, 32'h0, 4'h0, 2'b00);
        push(1, 32'h100C, 32'h55AA55AA, 4'hC, 2'b01);
        wait_sig("cpl_valid_seen", 0, 200);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_ready_low", {b.req_ready, b.req_valid}, 2'b01);
        end
        cpl_hold = 0;
        wait_cpl(6, 300);

        // reset in RD_RESP before rvalid: no completion afterwards
        r_hold = 1;
        push(0, 32'h1000, 32'h0, 4'h0, 2'b00);
        wait_sig("rready_seen", 1, 200);
        base = ncpl;
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("rst_mid_outs", {b.rready, b.arvalid, b.cpl_valid, b.bready, b.awvalid, b.wvalid}, 0);
        chk("rst_mid_ready", b.req_ready, 1);
        r_hold = 0;
        repeat (20) @(negedge clk);
        chk("rst_no_cpl", ncpl, base);

        // random stream: 8 alternating, then mixed
        aw_pct = 50; w_pct = 50; ar_pct = 50; cpl_pct = 60;
        for (int i = 0; i < 40; i++)
            push((i < 8) ? ((i % 2) == 0) : $urandom_range(1, 0),
                 32'h1000 + 4 * $urandom_range(7, 0), $urandom, 4'($urandom_range(15, 0)),
                 2'($urandom_range(3, 0)));
        wait_cpl(base + 40, 4000);
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/apb2axi_axi_master.md
Name: apb2axi_axi_master

Overview:
- Downstream consumer of the APB2AXI request FIFO.
- Pops one packed request entry at a time and executes it as a single-beat AXI transaction: AW/W/B for writes, AR/R for reads.
- Returns the response (resp, read data) on a completion valid/ready channel toward the APB-side response logic.
- Only one transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, AXI/request address width.
- DATA_W, 32, data width; must be a multiple of 8.
- ENTRY_WIDTH, 1+ADDR_W+DATA_W+DATA_W/8, request entry width; must equal the FIFO ENTRY_WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  FIFO pop_valid
- req_ready  out  1  FIFO pop_ready
- req_data  in  ENTRY_WIDTH  entry, MSB first: {is_write, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}
- awaddr  out  ADDR_W  write address
- awvalid  out  1  write address valid
- awready  in  1  write address ready
- wdata  out  DATA_W  write data
- wstrb  out  DATA_W/8  write strobes
- wvalid  out  1  write data valid
- wready  in  1  write data ready
- bresp  in  2  write response
- bvalid  in  1  write response valid
- bready  out  1  write response ready
- araddr  out  ADDR_W  read address
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rdata  in  DATA_W  read data
- rresp  in  2  read response
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- cpl_valid  out  1  completion valid
- cpl_ready  in  1  completion ready
- cpl_is_write  out  1  completion belongs to a write
- cpl_resp  out  2  AXI resp of the transaction
- cpl_rdata  out  DATA_W  read data; 0 for writes

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- All outputs are registered, except req_ready = (state==IDLE) && !reset.
- Reset values: every valid/ready output 0; awaddr, wdata, wstrb, araddr, cpl_rdata, cpl_resp, cpl_is_write all 0; state IDLE.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, CPL.
- IDLE:
  - On req_valid && req_ready, latch the entry.
  - is_write=1 -> WR_REQ: next cycle awvalid=wvalid=1 with awaddr/wdata/wstrb from the entry.
  - is_write=0 -> RD_REQ: next cycle arvalid=1, araddr=addr.
  - Latency from pop to first AXI valid is 1 cycle.
- WR_REQ:
  - aw_done/w_done flags track the two handshakes independently.
  - Each valid drops the cycle after its own handshake.
  - AW and W may complete in either order or in the same cycle.
  - When both are done (including same-cycle), go to WR_RESP and clear the flags.
- WR_RESP: bready=1. On bvalid: capture bresp, set cpl_is_write=1, cpl_rdata=0, go to CPL.
- RD_REQ: hold arvalid and araddr stable until arready. Then go to RD_RESP with arvalid=0.
- RD_RESP: rready=1. On rvalid: capture rdata and rresp (rdata is captured even when rresp!=OKAY), cpl_is_write=0, go to CPL.
- bready and rready are 0 in all other states.
- Entry B/R beats that arrive early are not accepted; they wait until WR_RESP/RD_RESP.
- CPL:
  - cpl_valid=1; cpl_* held stable until cpl_ready.
  - On the handshake: cpl_valid drops next cycle, go to IDLE.
  - req_ready rises the cycle after the completion handshake; back-to-back requests have no combinational path.
- AXI valids never drop before their handshake. AXI payload is stable while its valid is high.
- Error responses (SLVERR/DECERR) are passed through unchanged; no retry.
- Reset mid-transaction: next cycle all valids/readies are 0, state is IDLE, the latched entry is discarded, and no completion is issued. This is a system-level reset; AXI rules across reset are not enforced.
- No timeout: a missing AXI response stalls the block indefinitely, with req_ready=0.

Test Plan:
- Write, AW/W ready same cycle: entry {1,0x1000,0xDEADBEEF,0xF}, awready=wready=1, bresp=00 one cycle later -> one AW and one W handshake; cpl_valid with cpl_is_write=1, cpl_resp=00, cpl_rdata=0.
- Write, W before AW: wready=1 at T+1, awready=1 at T+4 -> wvalid=0 from T+2, awvalid held with awaddr stable through T+4, bready first asserted T+5.
- Read with error: entry {0,0x2004,...}, arready delayed 3 cycles, rdata=0x12345678, rresp=10 -> arvalid high 4 cycles; cpl_rdata=0x12345678, cpl_resp=10, cpl_is_write=0.
- Completion backpressure: cpl_ready=0 for 5 cycles with a second request waiting -> cpl_* stable, req_ready=0 throughout; second pop occurs the cycle after cpl_ready=1.
- Reset mid-read: reset asserted in RD_RESP before rvalid -> next cycle rready=arvalid=cpl_valid=0, req_ready=1 after reset releases, and no completion is produced.
- Back-to-back stream: 8 alternating write/read entries with random ready delays -> 8 completions in order, each matching its AXI response, with exactly one AXI transaction outstanding at any time.
